// File: rtl/lite16_pkg.sv
// -----------------------------------------------------------------------------
// lite16_pkg
// Shared definitions for the LITE-16 core front end:
//   WORD_W        instruction / address width (word addressed)
//   RESET_PC      default first fetch address after reset
//   HALT_OPCODE   instruction word that halts fetch when FETCH_HALT_EN is built
//   fetch_state_t fetch FSM states
//   pc_inc()      program-counter increment, modulo 2^WORD_W
// -----------------------------------------------------------------------------
package lite16_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC    = 16'h0000;
  localparam logic [WORD_W-1:0] HALT_OPCODE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // Wraps 16'hFFFF -> 16'h0000 silently; there is no overflow flag.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(1);
  endfunction

endpackage : lite16_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage of the LITE-16 core. Owns the program counter, issues
// one word read at a time to instruction memory (req/ack) and hands each fetched
// word plus its address to decode (valid/ready). Execute can redirect fetch with
// a one-cycle br_valid pulse at any time; a request already in flight to memory
// is allowed to complete and its word is thrown away.
//
// Build option: FETCH_HALT_EN
//   defined   -> adds output 'halted'; a fetched 16'hFFFF word stops fetch for
//                good (only rst recovers).
//   undefined -> no 'halted' port; 16'hFFFF is an ordinary instruction.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   imem_req     out  1       read request, held until imem_ack
//   imem_addr    out  WORD_W  word address, stable while imem_req is high
//   imem_ack     in   1       one-cycle pulse: imem_rdata valid, request done
//   imem_rdata   in   WORD_W  fetched instruction word
//   instr_valid  out  1       instr / instr_pc hold a word for decode
//   instr_ready  in   1       decode takes the word when valid & ready
//   instr        out  WORD_W  fetched instruction
//   instr_pc     out  WORD_W  address of instr
//   br_valid     in   1       one-cycle redirect pulse from execute
//   br_target    in   WORD_W  redirect address, sampled with br_valid
//   halted       out  1       (FETCH_HALT_EN only) halt opcode reached
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                WORD_W   = lite16_pkg::WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC = lite16_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              br_valid,
  input  logic [WORD_W-1:0] br_target
`ifdef FETCH_HALT_EN
  ,
  output logic              halted
`endif
);

  import lite16_pkg::*;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;

  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] w_fetch_pc_nxt;

  // Set when a redirect arrives while a request is outstanding: the word that
  // request returns belongs to the old path and must be dropped.
  logic              r_kill;
  logic              w_kill_nxt;

  logic              r_imem_req;
  logic              w_imem_req_nxt;
  logic [WORD_W-1:0] r_imem_addr;
  logic [WORD_W-1:0] w_imem_addr_nxt;

  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] w_instr_nxt;
  logic [WORD_W-1:0] r_instr_pc;
  logic [WORD_W-1:0] w_instr_pc_nxt;

`ifdef FETCH_HALT_EN
  logic              r_halted;
  logic              w_halted_nxt;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block; a path that
  // forgot one would otherwise infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_kill_nxt        = r_kill;
    w_imem_req_nxt    = r_imem_req;
    w_imem_addr_nxt   = r_imem_addr;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
`ifdef FETCH_HALT_EN
    w_halted_nxt      = r_halted;
`endif

    unique case (r_state)
      IDLE: begin
        // First request goes out one cycle after reset release; a redirect
        // arriving here simply replaces the start address.
        w_state_nxt    = REQ;
        w_imem_req_nxt = 1'b1;
        if (br_valid) begin
          w_fetch_pc_nxt  = br_target;
          w_imem_addr_nxt = br_target;
        end else begin
          w_imem_addr_nxt = r_fetch_pc;
        end
      end

      REQ: begin
        if (imem_ack) begin
          if (br_valid) begin
            // Redirect coincides with the returning word: drop the word and
            // reissue at the target back-to-back, nothing left to kill.
            w_fetch_pc_nxt  = br_target;
            w_kill_nxt      = 1'b0;
            w_imem_addr_nxt = br_target;
          end else if (r_kill) begin
            // Stale word from before a redirect; fetch_pc already holds the
            // target, so reissue from it without leaving REQ.
            w_kill_nxt      = 1'b0;
            w_imem_addr_nxt = r_fetch_pc;
`ifdef FETCH_HALT_EN
          end else if (imem_rdata == HALT_OPCODE) begin
            w_state_nxt    = HALT;
            w_imem_req_nxt = 1'b0;
            w_halted_nxt   = 1'b1;
`endif
          end else begin
            w_state_nxt       = HOLD;
            w_imem_req_nxt    = 1'b0;
            w_instr_valid_nxt = 1'b1;
            w_instr_nxt       = imem_rdata;
            w_instr_pc_nxt    = r_fetch_pc;
            w_fetch_pc_nxt    = pc_inc(r_fetch_pc);
          end
        end else if (br_valid) begin
          // Request is in flight and must finish at its original address;
          // remember the target and mark its data as stale. A later redirect
          // simply overwrites the target.
          w_fetch_pc_nxt = br_target;
          w_kill_nxt     = 1'b1;
        end
      end

      HOLD: begin
        if (br_valid) begin
          w_state_nxt       = REQ;
          w_instr_valid_nxt = 1'b0;
          w_fetch_pc_nxt    = br_target;
          w_imem_req_nxt    = 1'b1;
          w_imem_addr_nxt   = br_target;
        end else if (instr_ready) begin
          w_state_nxt       = REQ;
          w_instr_valid_nxt = 1'b0;
          w_imem_req_nxt    = 1'b1;
          w_imem_addr_nxt   = r_fetch_pc;
        end
      end

      HALT: begin
        // Terminal: only rst leaves this state; all inputs are ignored.
        w_imem_req_nxt    = 1'b0;
        w_instr_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_kill        <= 1'b0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
`ifdef FETCH_HALT_EN
      r_halted      <= 1'b0;
`endif
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_kill        <= w_kill_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_imem_addr   <= w_imem_addr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
`ifdef FETCH_HALT_EN
      r_halted      <= w_halted_nxt;
`endif
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
`ifdef FETCH_HALT_EN
  assign halted      = r_halted;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Instance dut uses RESET_PC = 0 and carries the
// main scenarios; instance dut_w uses RESET_PC = 16'hFFFF for the PC wrap case.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        br_valid;
  logic [15:0] br_target;

  logic        rst_w;
  logic        req_w;
  logic [15:0] addr_w;
  logic        ack_w;
  logic [15:0] rdata_w;
  logic        valid_w;
  logic        ready_w;
  logic [15:0] instr_w;
  logic [15:0] pc_w;

`ifdef FETCH_HALT_EN
  logic        halted;
  logic        halted_w;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .br_valid    (br_valid),
    .br_target   (br_target)
`ifdef FETCH_HALT_EN
    ,
    .halted      (halted)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk         (clk),
    .rst         (rst_w),
    .imem_req    (req_w),
    .imem_addr   (addr_w),
    .imem_ack    (ack_w),
    .imem_rdata  (rdata_w),
    .instr_valid (valid_w),
    .instr_ready (ready_w),
    .instr       (instr_w),
    .instr_pc    (pc_w),
    .br_valid    (1'b0),
    .br_target   (16'h0000)
`ifdef FETCH_HALT_EN
    ,
    .halted      (halted_w)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Bounded wait for imem_req on dut.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Return one word on dut's memory port after 'delay' wait cycles; leaves the
  // bench on the falling edge following the ack cycle.
  task automatic do_fetch(input logic [15:0] data, input int delay);
    for (int i = 0; i < delay; i++) step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0000/0000", instr, instr_pc); end
`ifdef FETCH_HALT_EN
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
`endif
    step();
    rst = 1'b0;
    step();
    // IDLE -> REQ one cycle after release.
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  // Ack two cycles after request; word visible the cycle after the ack.
  task automatic test_basic_fetch();
    instr_ready = 1'b1;
    do_fetch(16'h1234, 2);
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", instr_valid); end
    checks++; if (instr !== 16'h1234 || instr_pc !== 16'h0000) begin failures++; $display("FAIL basic_word got=%h@%h exp=1234@0000", instr, instr_pc); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%b exp=0", imem_req); end
    step();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      failures++; $display("FAIL basic_next got=v%b r%b a%h exp=v0 r1 a0001", instr_valid, imem_req, imem_addr);
    end
  endtask

  // Decode stalls for 5 cycles: word held, no memory traffic.
  task automatic test_hold_stall();
    instr_ready = 1'b0;
    do_fetch(16'hABCD, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'hABCD || instr_pc !== 16'h0001 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_cycle%0d got=v%b %h@%h r%b exp=v1 abcd@0001 r0", i, instr_valid, instr, instr_pc, imem_req);
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      failures++; $display("FAIL stall_release got=v%b r%b a%h exp=v0 r1 a0002", instr_valid, imem_req, imem_addr);
    end
  endtask

  // Redirect one cycle before the ack of address 0005.
  task automatic test_redirect_inflight();
    logic [15:0] a;
    for (int k = 2; k < 5; k++) begin
      a = 16'(k);
      checks++; if (imem_addr !== a) begin failures++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, a); end
      do_fetch(16'h2000 + a, 0);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== a) begin failures++; $display("FAIL seq_pc got=v%b %h exp=v1 %h", instr_valid, instr_pc, a); end
      step();
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin failures++; $display("FAIL br_pre got=r%b a%h exp=r1 a0005", imem_req, imem_addr); end
    br_valid  = 1'b1;
    br_target = 16'h0040;
    step();
    br_valid  = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin failures++; $display("FAIL br_addr_stable got=r%b a%h exp=r1 a0005", imem_req, imem_addr); end
    do_fetch(16'hDEAD, 0);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL br_killed_valid got=%b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failures++; $display("FAIL br_new_req got=r%b a%h exp=r1 a0040", imem_req, imem_addr); end
    do_fetch(16'h0BEE, 0);
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h0BEE || instr_pc !== 16'h0040) begin
      failures++; $display("FAIL br_target_word got=v%b %h@%h exp=v1 0bee@0040", instr_valid, instr, instr_pc);
    end
    step();
  endtask

  // Redirect in the same cycle as the ack: next request immediately at target.
  task automatic test_back_to_back();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0041) begin failures++; $display("FAIL b2b_pre got=r%b a%h exp=r1 a0041", imem_req, imem_addr); end
    br_valid  = 1'b1;
    br_target = 16'h0100;
    do_fetch(16'h5555, 0);
    br_valid  = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      failures++; $display("FAIL b2b_redirect got=v%b r%b a%h exp=v0 r1 a0100", instr_valid, imem_req, imem_addr);
    end
    do_fetch(16'h7777, 0);
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h7777 || instr_pc !== 16'h0100) begin
      failures++; $display("FAIL b2b_word got=v%b %h@%h exp=v1 7777@0100", instr_valid, instr, instr_pc);
    end
    step();
  endtask

  // RESET_PC = FFFF instance: two fetches, PC wraps.
  task automatic test_wrap();
    step();
    rst_w = 1'b0;
    step();
    checks++; if (req_w !== 1'b1 || addr_w !== 16'hFFFF) begin failures++; $display("FAIL wrap_req0 got=r%b a%h exp=r1 affff", req_w, addr_w); end
    ack_w = 1'b1; rdata_w = 16'h0A0A;
    step();
    ack_w = 1'b0;
    checks++; if (valid_w !== 1'b1 || pc_w !== 16'hFFFF) begin failures++; $display("FAIL wrap_pc0 got=v%b %h exp=v1 ffff", valid_w, pc_w); end
    step();
    checks++; if (req_w !== 1'b1 || addr_w !== 16'h0000) begin failures++; $display("FAIL wrap_req1 got=r%b a%h exp=r1 a0000", req_w, addr_w); end
    ack_w = 1'b1; rdata_w = 16'h0B0B;
    step();
    ack_w = 1'b0;
    checks++; if (valid_w !== 1'b1 || pc_w !== 16'h0000 || instr_w !== 16'h0B0B) begin
      failures++; $display("FAIL wrap_pc1 got=v%b %h@%h exp=v1 0b0b@0000", valid_w, instr_w, pc_w);
    end
  endtask

  // Asynchronous reset while a request is open, then while a word is held.
  task automatic test_reset_midop();
    bit ok;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", imem_req); end
    #1 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL rstmid_async got=r%b v%b a%h exp=r0 v0 a0000", imem_req, instr_valid, imem_addr);
    end
    step();
    rst = 1'b0;
    wait_req(ok);
    checks++; if (!ok || imem_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_restart got=ok%b a%h exp=ok1 a0000", ok, imem_addr); end
    instr_ready = 1'b0;
    do_fetch(16'h1111, 0);
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL rstmid_hold got=%b exp=1", instr_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000) begin
      failures++; $display("FAIL rstmid_valid got=v%b %h@%h exp=v0 0000@0000", instr_valid, instr, instr_pc);
    end
    step();
    rst = 1'b0;
    instr_ready = 1'b1;
    wait_req(ok);
    checks++; if (!ok || imem_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_restart2 got=ok%b a%h exp=ok1 a0000", ok, imem_addr); end
  endtask

  // Halt opcode: terminal with FETCH_HALT_EN, ordinary word otherwise.
  task automatic test_halt_opcode();
    do_fetch(16'hFFFF, 0);
`ifdef FETCH_HALT_EN
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL halt_enter got=h%b v%b r%b exp=h1 v0 r0", halted, instr_valid, imem_req);
    end
    br_valid  = 1'b1;
    br_target = 16'h0200;
    step();
    br_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        failures++; $display("FAIL halt_stay%0d got=h%b r%b v%b exp=h1 r0 v0", i, halted, imem_req, instr_valid);
      end
      step();
    end
`else
    checks++; if (instr_valid !== 1'b1 || instr !== 16'hFFFF || instr_pc !== 16'h0000) begin
      failures++; $display("FAIL ffff_normal got=v%b %h@%h exp=v1 ffff@0000", instr_valid, instr, instr_pc);
    end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      failures++; $display("FAIL ffff_next got=r%b a%h exp=r1 a0001", imem_req, imem_addr);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b1;
    br_valid    = 1'b0;
    br_target   = 16'h0000;
    rst_w       = 1'b1;
    ack_w       = 1'b0;
    rdata_w     = 16'h0000;
    ready_w     = 1'b1;

    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_inflight();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    test_halt_opcode();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
